// File: rtl/dm_access_unit.sv
// dm_access_unit: MEM-stage load/store to word bus with byte lanes, load extension and bus timeout.
// Define MISALIGN_TRAP_EN to fault misaligned half/word accesses without issuing a bus cycle.
module dm_access_unit #(
   parameter int BUS_TIMEOUT = 16,
   parameter int CNT_W = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        acc_valid,
   input  logic        acc_we,
   input  logic [2:0]  acc_type,
   input  logic [31:0] acc_addr,
   input  logic [31:0] acc_wdata,
   output logic        acc_stall,
   output logic        acc_done,
   output logic [31:0] acc_rdata,
   output logic        acc_fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;
   logic [1:0] state;
   logic [CNT_W-1:0] cnt;
   logic [2:0] type_q;
   logic [1:0] off_q, off;
   logic is_half, is_byte, misalign, q_half, q_byte, q_sgn, last;
   logic [3:0] be_nxt;
   logic [31:0] wd_nxt, ext;
   logic [7:0] rb;
   logic [15:0] rh;
   always_comb begin
      off = acc_addr[1:0];
      is_half = acc_type == 3'd1 || acc_type == 3'd2;
      is_byte = acc_type == 3'd3 || acc_type == 3'd4;
      be_nxt = is_byte ? 4'b0001 << off : is_half ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wd_nxt = is_byte ? {4{acc_wdata[7:0]}} : is_half ? {2{acc_wdata[15:0]}} : acc_wdata;
      q_half = type_q == 3'd1 || type_q == 3'd2;
      q_byte = type_q == 3'd3 || type_q == 3'd4;
      q_sgn = type_q == 3'd1 || type_q == 3'd3;
      rb = bus_rdata[{off_q, 3'b000} +: 8];
      rh = bus_rdata[{off_q[1], 4'b0000} +: 16];
      ext = q_byte ? {{24{q_sgn & rb[7]}}, rb} : q_half ? {{16{q_sgn & rh[15]}}, rh} : bus_rdata;
      last = cnt == CNT_W'(BUS_TIMEOUT - 2);
      acc_done = state == RESP;
      acc_stall = (state == IDLE && acc_valid) || state == BUSY;
   end
`ifdef MISALIGN_TRAP_EN
   assign misalign = is_half ? off[0] : !is_byte && off != 2'b00;
`else
   assign misalign = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         bus_req <= 1'b0;
         bus_we <= 1'b0;
         bus_addr <= '0;
         bus_be <= '0;
         bus_wdata <= '0;
         acc_rdata <= '0;
         acc_fault <= 1'b0;
         type_q <= '0;
         off_q <= '0;
      end else begin
         case (state)
            IDLE: if (acc_valid) begin
               type_q <= acc_type;
               off_q <= off;
               bus_we <= acc_we;
               bus_addr <= {acc_addr[31:2], 2'b00};
               bus_be <= be_nxt;
               bus_wdata <= wd_nxt;
               acc_rdata <= '0;
               acc_fault <= misalign;
               bus_req <= !misalign;
               state <= misalign ? RESP : BUSY;
            end
            BUSY: if (bus_ack) begin
               acc_rdata <= ext;
               bus_req <= 1'b0;
               cnt <= '0;
               state <= RESP;
            end else if (last) begin
               acc_rdata <= '0;
               acc_fault <= 1'b1;
               bus_req <= 1'b0;
               cnt <= '0;
               state <= RESP;
            end else begin
               cnt <= cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
